// File: rtl/mips_ctrl_pkg.sv
// Shared types for the multi-cycle MIPS control unit: FSM states, opcode map,
// ALU function codes and the decoded control-field bundle.
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_e;

    localparam logic [3:0] OP_RTYPE = 4'd0;
    localparam logic [3:0] OP_ADDI  = 4'd1;
    localparam logic [3:0] OP_ANDI  = 4'd2;
    localparam logic [3:0] OP_ORI   = 4'd3;
    localparam logic [3:0] OP_SLTI  = 4'd4;
    localparam logic [3:0] OP_LW    = 4'd5;
    localparam logic [3:0] OP_SW    = 4'd6;
    localparam logic [3:0] OP_BEQ   = 4'd7;
    localparam logic [3:0] OP_BNE   = 4'd8;
    localparam logic [3:0] OP_NOP   = 4'd9;

    localparam logic [2:0] ALU_FUNCT = 3'd0;
    localparam logic [2:0] ALU_ADD   = 3'd1;
    localparam logic [2:0] ALU_AND   = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_SLT   = 3'd4;
    localparam logic [2:0] ALU_SUB   = 3'd5;

    typedef struct packed {
        logic       reg_dest;
        logic       alu_src;
        logic       mem_to_reg;
        logic       branch_eq;
        logic       branch_not_eq;
        logic       is_load;
        logic       is_store;
        logic       is_nop;
        logic [2:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational opcode -> control-field lookup with a legality flag.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4
) (
    input  logic [OPCODE_W-1:0] i_op,
    output ctrl_t               o_ctrl,
    output logic                o_legal
);

    logic w_hi;
    assign w_hi = |(i_op >> 4);

    always_comb begin
        o_ctrl  = '0;
        o_legal = !w_hi;
        unique case (i_op[3:0])
            OP_RTYPE: begin o_ctrl.reg_dest = 1'b1; o_ctrl.alu_op = ALU_FUNCT; end
            OP_ADDI:  begin o_ctrl.alu_src  = 1'b1; o_ctrl.alu_op = ALU_ADD;   end
            OP_ANDI:  begin o_ctrl.alu_src  = 1'b1; o_ctrl.alu_op = ALU_AND;   end
            OP_ORI:   begin o_ctrl.alu_src  = 1'b1; o_ctrl.alu_op = ALU_OR;    end
            OP_SLTI:  begin o_ctrl.alu_src  = 1'b1; o_ctrl.alu_op = ALU_SLT;   end
            OP_LW: begin
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.is_load    = 1'b1;
                o_ctrl.alu_op     = ALU_ADD;
            end
            OP_SW: begin
                o_ctrl.alu_src  = 1'b1;
                o_ctrl.is_store = 1'b1;
                o_ctrl.alu_op   = ALU_ADD;
            end
            OP_BEQ:   begin o_ctrl.branch_eq     = 1'b1; o_ctrl.alu_op = ALU_SUB; end
            OP_BNE:   begin o_ctrl.branch_not_eq = 1'b1; o_ctrl.alu_op = ALU_SUB; end
            OP_NOP:   o_ctrl.is_nop = 1'b1;
            default:  o_legal = 1'b0;
        endcase
        if (!o_legal) o_ctrl = '0;
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a memory
// ready handshake. Define MIPS_CTRL_ILLEGAL_TRAP_EN to trap on illegal opcodes.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int ALU_OP_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                pc_write,
    output logic                ir_write,
    output logic                reg_dest,
    output logic                alu_src,
    output logic                mem_to_reg,
    output logic                branch_eq,
    output logic                branch_not_eq,
    output logic                mem_read,
    output logic                mem_write,
    output logic                reg_write,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                instr_done,
    output logic [2:0]          state,
    output logic                illegal_op
);

    state_e              r_state, w_next;
    logic [OPCODE_W-1:0] r_op;
    logic [OPCODE_W-1:0] w_dec_op;
    ctrl_t               w_ctrl;
    logic                w_legal;
    logic [2:0]          w_alu_op;

    // DECODE must see the opcode it is latching so a nop can finish that cycle.
    assign w_dec_op = (r_state == S_DECODE) ? opcode : r_op;

    mips_ctrl_decode #(.OPCODE_W(OPCODE_W)) u_decode (
        .i_op    (w_dec_op),
        .o_ctrl  (w_ctrl),
        .o_legal (w_legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) r_op <= opcode;
        end
    end

    always_comb begin
        w_next        = r_state;
        mem_req       = 1'b0;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        reg_dest      = 1'b0;
        alu_src       = 1'b0;
        mem_to_reg    = 1'b0;
        branch_eq     = 1'b0;
        branch_not_eq = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        w_alu_op      = 3'd0;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;

        if (r_state inside {S_EXEC, S_MEM, S_WB}) begin
            reg_dest   = w_ctrl.reg_dest;
            alu_src    = w_ctrl.alu_src;
            mem_to_reg = w_ctrl.mem_to_reg;
            w_alu_op   = w_ctrl.alu_op;
        end

        unique case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!w_legal) begin
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
                    w_next = S_TRAP;
`else
                    w_next     = S_FETCH;
                    instr_done = 1'b1;
`endif
                end else if (w_ctrl.is_nop) begin
                    w_next     = S_FETCH;
                    instr_done = 1'b1;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                branch_eq     = w_ctrl.branch_eq;
                branch_not_eq = w_ctrl.branch_not_eq;
                if (w_ctrl.branch_eq || w_ctrl.branch_not_eq) begin
                    w_next     = S_FETCH;
                    instr_done = 1'b1;
                end else if (w_ctrl.is_load || w_ctrl.is_store) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                mem_req   = 1'b1;
                mem_read  = w_ctrl.is_load;
                mem_write = w_ctrl.is_store;
                if (mem_ready) begin
                    if (w_ctrl.is_load) begin
                        w_next = S_WB;
                    end else begin
                        w_next     = S_FETCH;
                        instr_done = 1'b1;
                    end
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
            S_TRAP: illegal_op = 1'b1;
`endif
            default: w_next = S_IDLE;
        endcase
    end

    assign alu_op = ALU_OP_W'(w_alu_op);
    assign state  = r_state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench: a per-instruction trace model pushes expected output vectors,
// a negedge monitor pops and compares them against the DUT.
module tb_mips_multicycle_control;

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] opcode = 4'd0;
    logic       mem_ready = 1'b0;
    logic       mem_req, pc_write, ir_write, reg_dest, alu_src, mem_to_reg;
    logic       branch_eq, branch_not_eq, mem_read, mem_write, reg_write;
    logic [2:0] alu_op;
    logic       instr_done;
    logic [2:0] state;
    logic       illegal_op;

    mips_multicycle_control #(.OPCODE_W(4), .ALU_OP_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .pc_write(pc_write), .ir_write(ir_write),
        .reg_dest(reg_dest), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
        .branch_eq(branch_eq), .branch_not_eq(branch_not_eq),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .alu_op(alu_op), .instr_done(instr_done), .state(state),
        .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req, pc_write, ir_write, reg_dest, alu_src, mem_to_reg;
        logic       branch_eq, branch_not_eq, mem_read, mem_write, reg_write;
        logic [2:0] alu_op;
        logic       instr_done;
        logic [2:0] state;
        logic       illegal_op;
    } obs_t;

    typedef struct {
        obs_t       exp;
        logic       rdy;
        logic [3:0] opc;
    } cyc_t;

    obs_t  sb_q[$];
    string tag_q[$];
    cyc_t  tr[$];
    int    n_vec = 0;
    int    n_err = 0;
    string tag = "reset";
    obs_t  act, m_exp;
    string m_tag;

    assign act = {mem_req, pc_write, ir_write, reg_dest, alu_src, mem_to_reg,
                  branch_eq, branch_not_eq, mem_read, mem_write, reg_write,
                  alu_op, instr_done, state, illegal_op};

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            m_exp = sb_q.pop_front();
            m_tag = tag_q.pop_front();
            n_vec++;
            if (act !== m_exp) begin
                n_err++;
                $display("FAIL %s: actual=%h required=%h (state act=%0d req=%0d)",
                         m_tag, act, m_exp, act.state, m_exp.state);
            end
        end
    end

    function automatic logic rbit();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] rop();
        return 4'($urandom_range(0, 15));
    endfunction

    // Datapath fields visible in EXEC/MEM/WB, straight from the opcode table.
    function automatic obs_t fld(input int op, input logic [2:0] st);
        obs_t e = '0;
        e.state      = st;
        e.reg_dest   = (op == 0);
        e.alu_src    = (op >= 1 && op <= 6);
        e.mem_to_reg = (op == 5);
        case (op)
            1, 5, 6: e.alu_op = 3'd1;
            2:       e.alu_op = 3'd2;
            3:       e.alu_op = 3'd3;
            4:       e.alu_op = 3'd4;
            7, 8:    e.alu_op = 3'd5;
            default: e.alu_op = 3'd0;
        endcase
        return e;
    endfunction

    task automatic add(input obs_t e, input logic rdy, input logic [3:0] opc);
        cyc_t c;
        c.exp = e; c.rdy = rdy; c.opc = opc;
        tr.push_back(c);
    endtask

    // Build the cycle-by-cycle trace of one instruction; returns 1 if it trapped.
    task automatic build(input int op, input int fs, input int ms, output bit trapped);
        obs_t e;
        bit lw = (op == 5), sw = (op == 6), br = (op == 7 || op == 8);
        trapped = 1'b0;
        for (int i = 0; i <= fs; i++) begin
            e = '0; e.state = 3'd1; e.mem_req = 1'b1; e.mem_read = 1'b1;
            e.pc_write = (i == fs); e.ir_write = (i == fs);
            add(e, i == fs, rop());
        end
        e = '0; e.state = 3'd2;
        if (op > 9 && TRAP_EN) begin
            add(e, rbit(), 4'(op));
            for (int i = 0; i < 4; i++) begin
                e = '0; e.state = 3'd6; e.illegal_op = 1'b1;
                add(e, rbit(), rop());
            end
            trapped = 1'b1;
            return;
        end
        if (op >= 9) begin
            e.instr_done = 1'b1;
            add(e, rbit(), 4'(op));
            return;
        end
        add(e, rbit(), 4'(op));
        e = fld(op, 3'd3);
        e.branch_eq = (op == 7); e.branch_not_eq = (op == 8); e.instr_done = br;
        add(e, rbit(), rop());
        if (br) return;
        if (lw || sw) begin
            for (int i = 0; i <= ms; i++) begin
                e = fld(op, 3'd4); e.mem_req = 1'b1; e.mem_read = lw; e.mem_write = sw;
                e.instr_done = sw && (i == ms);
                add(e, i == ms, rop());
            end
            if (sw) return;
        end
        e = fld(op, 3'd5); e.reg_write = 1'b1; e.instr_done = 1'b1;
        add(e, rbit(), rop());
    endtask

    task automatic play(input int limit);
        cyc_t c;
        int   k = 0;
        while (tr.size() > 0 && k < limit) begin
            c = tr.pop_front();
            sb_q.push_back(c.exp); tag_q.push_back(tag);
            mem_ready = c.rdy; opcode = c.opc;
            @(posedge clk); #1;
            k++;
        end
        tr.delete();
    endtask

    // n cycles in reset, then one IDLE cycle; all outputs zero throughout.
    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            sb_q.push_back('0); tag_q.push_back("reset");
            rst_n = 1'b0; mem_ready = rbit(); opcode = rop();
            @(posedge clk); #1;
        end
        sb_q.push_back('0); tag_q.push_back("idle");
        rst_n = 1'b1; mem_ready = rbit(); opcode = rop();
        @(posedge clk); #1;
    endtask

    task automatic instr(input string t, input int op, input int fs, input int ms);
        bit trapped;
        tag = t;
        build(op, fs, ms, trapped);
        play(1000);
        if (trapped) do_reset(2);
    endtask

    initial begin
        int op, fs, ms, cut;
        bit trapped;
        @(posedge clk); #1;
        do_reset(3);
        instr("addi",        1, 0, 0);
        instr("lw_memstall", 5, 0, 2);
        instr("beq",         7, 0, 0);
        instr("fetchstall",  1, 4, 0);
        instr("rtype",       0, 0, 0);
        instr("sw",          6, 1, 1);
        instr("bne",         8, 0, 0);
        instr("nop",         9, 0, 0);
        instr("illegal12",  12, 0, 0);
        instr("slti",        4, 0, 0);
        for (int n = 0; n < 80; n++) begin
            op = $urandom_range(0, 15);
            fs = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            ms = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            if (n % 16 == 15) begin
                tag = "midreset";
                build(op, fs, ms, trapped);
                cut = $urandom_range(1, tr.size());
                play(cut);
                do_reset($urandom_range(1, 2));
            end else begin
                instr("random", op, fs, ms);
            end
        end
        @(negedge clk); #1;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: actual=%0d pending required=0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
